// File: rtl/change_pkg.sv
// Shared types, coin codes and helpers for the change dispenser.
package change_pkg;

  typedef logic [2:0] coin_t;
  typedef logic [1:0] count_t;

  localparam coin_t COIN_NONE = 3'b000;
  localparam coin_t COIN_PENT = 3'b100;
  localparam coin_t COIN_TRI  = 3'b010;
  localparam coin_t COIN_CIRC = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    EJECT1,
    EJECT2,
    DONE,
    JAM
  } disp_state_t;

  // A slot code is legal when empty or exactly one coin type.
  function automatic logic coin_legal(input coin_t c);
    return (c == COIN_NONE) || (c == COIN_PENT) || (c == COIN_TRI) || (c == COIN_CIRC);
  endfunction

  function automatic count_t coin_count(input coin_t c, input count_t p, input count_t t,
                                        input count_t ci);
    if (c == COIN_PENT) return p;
    if (c == COIN_TRI)  return t;
    if (c == COIN_CIRC) return ci;
    return '0;
  endfunction

endpackage

// File: rtl/coin_bin.sv
// One coin type's inventory: saturating 2-bit count with decrement and restock.
module coin_bin
  import change_pkg::*;
#(
  parameter int unsigned InitCount = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   dec_i,
  input  logic   inc_en_i,
  input  count_t inc_amt_i,
  output count_t count_o,
  output logic   is_zero_o
);

  count_t     count_q, count_d;
  logic [2:0] sum;

  always_comb begin
    sum     = {1'b0, count_q} + {1'b0, inc_amt_i};
    count_d = count_q;
    if (dec_i && (count_q != 2'd0)) begin
      count_d = count_q - 2'd1;
    end else if (inc_en_i) begin
      count_d = (sum > 3'd3) ? 2'd3 : sum[1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= count_t'(InitCount);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_zero_o = (count_q == 2'd0);

endmodule

// File: rtl/change_dispenser.sv
// Latches the change maker's two-coin decision, ejects the coins over valid/ready,
// and owns the coin inventory with jam detection and restocking.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned INIT_COUNT = 2
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       Start,
  input  logic [2:0] FirstCoin,
  input  logic [2:0] SecondCoin,
  input  logic       Restock,
  input  logic [1:0] RestockP,
  input  logic [1:0] RestockT,
  input  logic [1:0] RestockC,
  input  logic       ClearJam,
  input  logic       EjectReady,
  output logic       EjectValid,
  output logic [2:0] EjectCoin,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles,
  output logic       Busy,
  output logic       Done,
  output logic       CoinError,
  output logic       ShortChange,
  output logic       Jam
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  disp_state_t state_q;
  coin_t       slot1_q, slot2_q, eject_coin_q;
  logic        eject_valid_q, busy_q, done_q, coin_error_q, short_change_q, jam_q;
  logic [7:0]  timer_q;

  count_t pent_cnt, tri_cnt, circ_cnt;
  logic   pent_zero, tri_zero, circ_zero;

  logic   handshake, restock_en, start_ok, first_short, first_active;
  coin_t  dec_vec, zero_vec;
  count_t slot2_inv;
  logic   slot2_active, slot2_short;

  always_comb begin
    handshake    = eject_valid_q & EjectReady;
    dec_vec      = handshake ? eject_coin_q : COIN_NONE;
    restock_en   = (state_q == IDLE) & Restock & ~Start;
    zero_vec     = {pent_zero, tri_zero, circ_zero};
    start_ok     = coin_legal(FirstCoin) & coin_legal(SecondCoin);
    first_short  = |(FirstCoin & zero_vec);
    first_active = (FirstCoin != COIN_NONE) & ~first_short;
    // Second slot must see the count after a same-type first coin leaves this edge.
    slot2_inv    = coin_count(slot2_q, pent_cnt, tri_cnt, circ_cnt);
    if ((state_q == EJECT1) && handshake && (slot1_q == slot2_q)) begin
      slot2_inv = slot2_inv - 2'd1;
    end
    slot2_active = (slot2_q != COIN_NONE) & (slot2_inv != 2'd0);
    slot2_short  = (slot2_q != COIN_NONE) & (slot2_inv == 2'd0);
  end

  coin_bin #(.InitCount(INIT_COUNT)) u_pent_bin (
    .clk_i    (clock),
    .rst_ni   (reset_L),
    .dec_i    (dec_vec[2]),
    .inc_en_i (restock_en),
    .inc_amt_i(RestockP),
    .count_o  (pent_cnt),
    .is_zero_o(pent_zero)
  );

  coin_bin #(.InitCount(INIT_COUNT)) u_tri_bin (
    .clk_i    (clock),
    .rst_ni   (reset_L),
    .dec_i    (dec_vec[1]),
    .inc_en_i (restock_en),
    .inc_amt_i(RestockT),
    .count_o  (tri_cnt),
    .is_zero_o(tri_zero)
  );

  coin_bin #(.InitCount(INIT_COUNT)) u_circ_bin (
    .clk_i    (clock),
    .rst_ni   (reset_L),
    .dec_i    (dec_vec[0]),
    .inc_en_i (restock_en),
    .inc_amt_i(RestockC),
    .count_o  (circ_cnt),
    .is_zero_o(circ_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state_q        <= IDLE;
      slot1_q        <= COIN_NONE;
      slot2_q        <= COIN_NONE;
      eject_coin_q   <= COIN_NONE;
      eject_valid_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      coin_error_q   <= 1'b0;
      short_change_q <= 1'b0;
      jam_q          <= 1'b0;
      timer_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            slot1_q        <= FirstCoin;
            slot2_q        <= SecondCoin;
            coin_error_q   <= ~start_ok;
            short_change_q <= start_ok & first_short;
            busy_q         <= 1'b1;
            timer_q        <= '0;
            if (!start_ok) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= EJECT1;
              eject_valid_q <= first_active;
              eject_coin_q  <= first_active ? FirstCoin : COIN_NONE;
            end
          end
        end
        EJECT1: begin
          if (!eject_valid_q || handshake) begin
            timer_q <= '0;
            if (slot2_active) begin
              state_q       <= EJECT2;
              eject_valid_q <= 1'b1;
              eject_coin_q  <= slot2_q;
            end else begin
              // An empty or unstockable second slot finishes straight away.
              state_q        <= DONE;
              done_q         <= 1'b1;
              eject_valid_q  <= 1'b0;
              eject_coin_q   <= COIN_NONE;
              short_change_q <= short_change_q | slot2_short;
            end
          end else if (timer_q == TimeoutLast) begin
            state_q       <= JAM;
            jam_q         <= 1'b1;
            eject_valid_q <= 1'b0;
            eject_coin_q  <= COIN_NONE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        EJECT2: begin
          if (!eject_valid_q || handshake) begin
            state_q       <= DONE;
            done_q        <= 1'b1;
            eject_valid_q <= 1'b0;
            eject_coin_q  <= COIN_NONE;
          end else if (timer_q == TimeoutLast) begin
            state_q       <= JAM;
            jam_q         <= 1'b1;
            eject_valid_q <= 1'b0;
            eject_coin_q  <= COIN_NONE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        JAM: begin
          if (ClearJam) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            jam_q   <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          jam_q         <= 1'b0;
          eject_valid_q <= 1'b0;
          eject_coin_q  <= COIN_NONE;
        end
      endcase
    end
  end

  assign EjectValid  = eject_valid_q;
  assign EjectCoin   = eject_coin_q;
  assign Pentagons   = pent_cnt;
  assign Triangles   = tri_cnt;
  assign Circles     = circ_cnt;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign CoinError   = coin_error_q;
  assign ShortChange = short_change_q;
  assign Jam         = jam_q;

endmodule
